// File: rtl/adc_ram_unpacker.sv
// Reads a capture RAM holding 4 frames per 3 words and streams one 96-bit,
// 8-channel frame per valid/ready transfer.
module adc_ram_unpacker #(
    parameter int RD_LATENCY = 2,
    parameter int MAX_FRAMES = 21844
) (
    input  logic         adc_clkinp,
    input  logic         iResetN,
    input  logic         iDataReady,
    input  logic [15:0]  iRecLength,
    output logic         oRDEN,
    output logic [13:0]  oRAddr,
    input  logic [127:0] iRAMData,
    output logic [95:0]  oFrameData,
    output logic         oFrameValid,
    input  logic         iFrameReady,
    output logic         oBusy,
    output logic         oDone,
    output logic [1:0]   oState
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_RUN   = 2'd1;
    localparam logic [1:0]  S_DONE  = 2'd2;
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAMES);

    logic [1:0]   r_state;
    logic         r_drdy_q;
    logic         r_armed;
    logic [15:0]  r_nframes;
    logic [16:0]  r_words_total;
    logic [16:0]  r_rd_cnt;
    logic         r_rden;
    logic [13:0]  r_raddr;
    logic [RD_LATENCY-1:0] r_vpipe;
    logic [127:0] r_fifo [4];
    logic [1:0]   r_wptr;
    logic [1:0]   r_rptr;
    logic [2:0]   r_fifo_cnt;
    logic [1:0]   r_phase;
    logic [15:0]  r_loaded;
    logic [15:0]  r_xfer;
    logic         r_fvalid;
    logic [95:0]  r_fdata;

    logic [15:0]  w_len;
    logic [16:0]  w_words;
    logic         w_start;
    logic         w_xfer;
    logic         w_last_xfer;
    logic         w_push;
    logic         w_pop;
    logic         w_load;
    logic         w_have;
    logic         w_need2;
    logic [1:0]   w_rptr_n1;
    logic [95:0]  w_frame;
    logic [3:0]   w_inflight;
    logic [3:0]   w_occ;
    logic         w_issue;

    // A start needs iDataReady to have been seen low since reset, so a level
    // that is already high at reset release is not mistaken for a rising edge.
    assign w_start = (r_state == S_IDLE) && r_armed && iDataReady && !r_drdy_q;
    assign w_len   = (iRecLength > MAX_LEN) ? MAX_LEN : iRecLength;
    assign w_words = 17'(({2'b00, w_len} * 18'd3 + 18'd3) >> 2);

    // Handshake: oFrameValid/oFrameData are registered and held unchanged until
    // a cycle with iFrameReady high; that cycle is the transfer.
    assign w_xfer      = r_fvalid && iFrameReady;
    assign w_last_xfer = w_xfer && (r_xfer == r_nframes - 16'd1);

    assign w_push    = r_vpipe[RD_LATENCY-1] && (r_state == S_RUN);
    assign w_rptr_n1 = r_rptr + 2'd1;

    // Frame phase selects which slices of the head (and following) word form
    // the frame; phases 1..3 finish the head word, so it is popped.
    always_comb begin
        w_frame = '0;
        w_need2 = 1'b0;
        case (r_phase)
            2'd0: w_frame = r_fifo[r_rptr][127:32];
            2'd1: begin
                w_frame = {r_fifo[r_rptr][31:0], r_fifo[w_rptr_n1][127:64]};
                w_need2 = 1'b1;
            end
            2'd2: begin
                w_frame = {r_fifo[r_rptr][63:0], r_fifo[w_rptr_n1][127:96]};
                w_need2 = 1'b1;
            end
            default: w_frame = r_fifo[r_rptr][95:0];
        endcase
    end

    assign w_have = w_need2 ? (r_fifo_cnt >= 3'd2) : (r_fifo_cnt != 3'd0);
    assign w_load = (r_state == S_RUN) && (!r_fvalid || w_xfer) &&
                    (r_loaded != r_nframes) && w_have;
    assign w_pop  = w_load && (r_phase != 2'd0);

    always_comb begin
        w_inflight = {3'b000, r_rden};
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + {3'b000, r_vpipe[i]};
        end
    end

    // Occupancy counts the word popped this cycle as already gone, so a freed
    // slot can be refilled without a bubble while never exceeding 4 words.
    assign w_occ   = {1'b0, r_fifo_cnt} + w_inflight - {3'b000, w_pop};
    assign w_issue = (r_state == S_RUN) && !w_last_xfer && (w_occ < 4'd4) &&
                     (r_rd_cnt < r_words_total);

    always_ff @(posedge adc_clkinp or negedge iResetN) begin
        if (!iResetN) begin
            r_state       <= S_IDLE;
            r_drdy_q      <= 1'b0;
            r_armed       <= 1'b0;
            r_nframes     <= '0;
            r_words_total <= '0;
        end else begin
            r_drdy_q <= iDataReady;
            if (!iDataReady) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_nframes     <= w_len;
                        r_words_total <= w_words;
                        r_state       <= (w_len == 16'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_last_xfer) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!iDataReady) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // oRAddr holds the address being read while oRDEN is high and advances
    // after each read, so it ends at the word count.
    always_ff @(posedge adc_clkinp or negedge iResetN) begin
        if (!iResetN) begin
            r_rden   <= 1'b0;
            r_raddr  <= '0;
            r_rd_cnt <= '0;
            r_vpipe  <= '0;
        end else begin
            r_vpipe[0] <= r_rden;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
            if (w_start) begin
                r_raddr  <= '0;
                r_rden   <= (w_len != 16'd0);
                r_rd_cnt <= (w_len != 16'd0) ? 17'd1 : 17'd0;
            end else begin
                if (r_rden) begin
                    r_raddr <= r_raddr + 14'd1;
                end
                r_rden <= w_issue;
                if (w_issue) begin
                    r_rd_cnt <= r_rd_cnt + 17'd1;
                end
            end
        end
    end

    always_ff @(posedge adc_clkinp) begin
        if (w_push) begin
            r_fifo[r_wptr] <= iRAMData;
        end
    end

    always_ff @(posedge adc_clkinp or negedge iResetN) begin
        if (!iResetN) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else if (w_start) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            r_fifo_cnt <= r_fifo_cnt + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    always_ff @(posedge adc_clkinp or negedge iResetN) begin
        if (!iResetN) begin
            r_fvalid <= 1'b0;
            r_fdata  <= '0;
            r_phase  <= '0;
            r_loaded <= '0;
            r_xfer   <= '0;
        end else if (w_start) begin
            r_fvalid <= 1'b0;
            r_phase  <= '0;
            r_loaded <= '0;
            r_xfer   <= '0;
        end else begin
            if (w_load) begin
                r_fdata  <= w_frame;
                r_fvalid <= 1'b1;
                r_phase  <= r_phase + 2'd1;
                r_loaded <= r_loaded + 16'd1;
            end else if (w_xfer) begin
                r_fvalid <= 1'b0;
            end
            if (w_xfer) begin
                r_xfer <= r_xfer + 16'd1;
            end
        end
    end

    assign oRDEN       = r_rden;
    assign oRAddr      = r_raddr;
    assign oFrameData  = r_fdata;
    assign oFrameValid = r_fvalid;
    assign oBusy       = (r_state == S_RUN);
    assign oDone       = (r_state == S_DONE);
    assign oState      = r_state;

endmodule
